// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction-fetch stage
package fetch_pkg;
    localparam int DEFAULT_IMEM_AW = 10;
    typedef enum logic {RUN, HALT} fetch_state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry FIFO of fetched {pc, inst} pairs with flush
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic [1:0]   count,
    output fetch_entry_t head
);
    fetch_entry_t [1:0] mem_q, mem_d;
    logic rd_q, rd_d, wr_q, wr_d;
    logic [1:0] count_q, count_d;
    // next state: flush empties the queue and beats any push/pop in that cycle
    always_comb begin
        mem_d = mem_q;
        if (push && !flush) mem_d[wr_q] = din;
        rd_d = flush ? 1'b0 : rd_q ^ pop;
        wr_d = flush ? 1'b0 : wr_q ^ push;
        count_d = flush ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
    end
    // storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            rd_q <= rd_d;
            wr_q <= wr_d;
            count_q <= count_d;
        end
    end
    assign count = count_q;
    assign head = mem_q[rd_q];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: issues imem reads at pc, tags responses and queues them for decode
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int IMEM_AW = DEFAULT_IMEM_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pc,
    input  logic               redirect,
    output logic               cta,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        inst,
    output logic [31:0]        inst_pc,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic               misaligned
);
    fetch_state_t state_q, state_d;
    logic misaligned_q, misaligned_d, inflight_q, inflight_d;
    logic [31:0] tag_q, tag_d;
    logic [1:0] count;
    logic [2:0] occ;
    logic aligned, pop, push, issue;
    fetch_entry_t head, push_entry;

    assign aligned = pc[1:0] == 2'b00;
    assign pop = inst_valid & inst_ready;
    // a response arriving in a redirect cycle belongs to the old stream
    assign push = inflight_q & !redirect;
    assign occ = {1'b0, count} + {2'b00, inflight_q};
    // rst gating keeps cta/imem_en low for the whole reset window
    assign issue = !rst && state_q == RUN && !redirect && aligned && occ < 3'd2 + {2'b00, pop};
    assign push_entry = '{pc: tag_q, inst: imem_rdata};

    // next state: redirect recovers from HALT, a misaligned pc in RUN halts
    always_comb begin
        state_d = state_q;
        misaligned_d = misaligned_q;
        if (redirect) begin
            state_d = RUN;
            misaligned_d = 1'b0;
        end else if (state_q == RUN && !aligned) begin
            state_d = HALT;
            misaligned_d = 1'b1;
        end
        inflight_d = issue;
        tag_d = issue ? pc : tag_q;
    end

    // FSM, fault flag, in-flight flag and pc tag of the outstanding read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            misaligned_q <= 1'b0;
            inflight_q <= 1'b0;
            tag_q <= '0;
        end else begin
            state_q <= state_d;
            misaligned_q <= misaligned_d;
            inflight_q <= inflight_d;
            tag_q <= tag_d;
        end
    end

    fetch_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (push_entry),
        .count (count),
        .head  (head)
    );

    assign cta = issue;
    assign imem_en = issue;
    assign imem_addr = pc[IMEM_AW+1:2];
    assign inst = head.inst;
    assign inst_pc = head.pc;
    assign inst_valid = count != 2'd0;
    assign misaligned = misaligned_q;
endmodule
